// File: rtl/bidir_ring_stop.sv
// bidir_ring_stop: one stop of a bidirectional ring NoC.
//   Port index 0 = local endpoint, 1 = clockwise (CW) link, 2 = counter-clockwise (CCW) link.
//   Each input has a FIFO of FLIT_BUFFER_DEPTH flits. The route is computed from the head flit's dest
//   (shortest direction, a tie goes CW), latched for the body and held until the tail pops.
//   Each output has round-robin arbitration, a wormhole lock and a downstream credit counter.
// Ports (per-port arrays are indexed 0..2):
//   clk, rst_n                   clock, synchronous active-low reset
//   data_in/dest_in/is_tail_in   incoming flit fields
//   send_in                      incoming flit valid
//   credit_out                   one pulse per flit popped from that input FIFO
//   data_out/dest_out/is_tail_out outgoing flit fields; they hold their last value while idle
//   send_out                     outgoing flit valid
//   credit_in                    credit returned by the downstream buffer
//   stat_flits_out               per-output sent-flit counters; present only with RING_STOP_STATS_EN
// Optional build macro: RING_STOP_STATS_EN
module bidir_ring_stop #(
  parameter int unsigned NUM_NODES         = 8,
  parameter int unsigned NODE_ID           = 0,
  parameter int unsigned DEST_WIDTH        = 4,
  parameter int unsigned FLIT_WIDTH        = 256,
  parameter int unsigned FLIT_BUFFER_DEPTH = 2,
  parameter int unsigned DISABLE_SELFLOOP  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in [3],
  input  logic [DEST_WIDTH-1:0] dest_in [3],
  input  logic [2:0]            is_tail_in,
  input  logic [2:0]            send_in,
  output logic [2:0]            credit_out,
  output logic [FLIT_WIDTH-1:0] data_out [3],
  output logic [DEST_WIDTH-1:0] dest_out [3],
  output logic [2:0]            is_tail_out,
  output logic [2:0]            send_out,
  input  logic [2:0]            credit_in
`ifdef RING_STOP_STATS_EN
  ,
  output logic [31:0]           stat_flits_out [3]
`endif
);

  localparam int unsigned CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int unsigned PTR_W = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FLIT_BUFFER_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FLIT_BUFFER_DEPTH - 1);

  // The encodings 0..2 equal the output port index; RT_DROP consumes a flit without sending it.
  typedef enum logic [1:0] {RT_LOCAL = 2'd0, RT_CW = 2'd1, RT_CCW = 2'd2, RT_DROP = 2'd3} route_e;

  function automatic route_e calc_route(input logic [DEST_WIDTH-1:0] dest, input int unsigned port);
    int unsigned dcw;
    dcw = (32'(dest) + NUM_NODES - NODE_ID) % NUM_NODES;
    if (dcw == 0) return (port == 0 && DISABLE_SELFLOOP != 0) ? RT_DROP : RT_LOCAL;
    else if (dcw <= NUM_NODES / 2) return RT_CW;
    else return RT_CCW;
  endfunction

  logic [FLIT_WIDTH-1:0]        fifo_data_q [3][FLIT_BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0]        fifo_dest_q [3][FLIT_BUFFER_DEPTH];
  logic [FLIT_BUFFER_DEPTH-1:0] fifo_tail_q [3];
  logic [PTR_W-1:0]             rd_q [3];
  logic [PTR_W-1:0]             wr_q [3];
  logic [CNT_W-1:0]             cnt_q [3];
  logic [CNT_W-1:0]             cnt_d [3];
  logic [2:0]                   mid_q;
  route_e                       route_q [3];
  logic [CNT_W-1:0]             cred_q [3];
  logic [CNT_W-1:0]             cred_d [3];
  logic [2:0]                   lock_v_q;
  logic [1:0]                   lock_in_q [3];
  logic [1:0]                   rr_q [3];
  logic [FLIT_WIDTH-1:0]        data_out_q [3];
  logic [DEST_WIDTH-1:0]        dest_out_q [3];
  logic [2:0]                   tail_out_q, send_out_q, credit_out_q;

  logic [2:0]            valid, head_tail, wr_en, pop, gnt_v;
  logic [FLIT_WIDTH-1:0] head_data [3];
  logic [DEST_WIDTH-1:0] head_dest [3];
  route_e                cur_route [3];
  logic [1:0]            gnt_in [3];

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      valid[i]     = (cnt_q[i] != '0);
      head_data[i] = fifo_data_q[i][rd_q[i]];
      head_dest[i] = fifo_dest_q[i][rd_q[i]];
      head_tail[i] = fifo_tail_q[i][rd_q[i]];
      // Body flits follow the route latched when the head popped.
      cur_route[i] = mid_q[i] ? route_q[i] : calc_route(head_dest[i], i);
      wr_en[i]     = send_in[i] && (cnt_q[i] != DEPTH_C);
    end
  end

  always_comb begin
    int unsigned cand;
    cand  = 0;
    gnt_v = '0;
    pop   = '0;
    for (int unsigned o = 0; o < 3; o++) begin
      gnt_in[o] = '0;
      for (int unsigned k = 0; k < 3; k++) begin
        cand = (32'(rr_q[o]) + k) % 3;
        if (!gnt_v[o] && valid[cand] && 32'(cur_route[cand]) == o && cred_q[o] != '0 &&
            (!lock_v_q[o] || 32'(lock_in_q[o]) == cand)) begin
          gnt_v[o]  = 1'b1;
          gnt_in[o] = 2'(cand);
        end
      end
    end
    for (int unsigned i = 0; i < 3; i++) pop[i] = valid[i] && (cur_route[i] == RT_DROP);
    for (int unsigned o = 0; o < 3; o++) if (gnt_v[o]) pop[gnt_in[o]] = 1'b1;
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      unique case ({wr_en[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
      cred_d[i] = cred_q[i];
      if (gnt_v[i] && !credit_in[i]) cred_d[i] = cred_q[i] - CNT_W'(1);
      else if (!gnt_v[i] && credit_in[i] && cred_q[i] != DEPTH_C) cred_d[i] = cred_q[i] + CNT_W'(1);
    end
  end

  // FIFO storage carries no reset; occupancy is tracked by the pointers and counts below.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (wr_en[i]) begin
        fifo_data_q[i][wr_q[i]] <= data_in[i];
        fifo_dest_q[i][wr_q[i]] <= dest_in[i];
        fifo_tail_q[i][wr_q[i]] <= is_tail_in[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mid_q        <= '0;
      lock_v_q     <= '0;
      tail_out_q   <= '0;
      send_out_q   <= '0;
      credit_out_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        rd_q[i]       <= '0;
        wr_q[i]       <= '0;
        cnt_q[i]      <= '0;
        route_q[i]    <= RT_LOCAL;
        cred_q[i]     <= DEPTH_C;
        lock_in_q[i]  <= '0;
        rr_q[i]       <= '0;
        data_out_q[i] <= '0;
        dest_out_q[i] <= '0;
      end
    end else begin
      credit_out_q <= pop;
      send_out_q   <= gnt_v;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt_q[i]  <= cnt_d[i];
        cred_q[i] <= cred_d[i];
        if (wr_en[i]) wr_q[i] <= (wr_q[i] == LAST_PTR) ? '0 : wr_q[i] + PTR_W'(1);
        if (pop[i]) begin
          rd_q[i]    <= (rd_q[i] == LAST_PTR) ? '0 : rd_q[i] + PTR_W'(1);
          mid_q[i]   <= !head_tail[i];
          route_q[i] <= cur_route[i];
        end
        if (gnt_v[i]) begin
          data_out_q[i] <= head_data[gnt_in[i]];
          dest_out_q[i] <= head_dest[gnt_in[i]];
          tail_out_q[i] <= head_tail[gnt_in[i]];
          // A tail releases the lock and moves priority past the winner; a non-tail locks the output.
          if (head_tail[gnt_in[i]]) begin
            lock_v_q[i] <= 1'b0;
            rr_q[i]     <= (gnt_in[i] == 2'd2) ? 2'd0 : gnt_in[i] + 2'd1;
          end else begin
            lock_v_q[i]  <= 1'b1;
            lock_in_q[i] <= gnt_in[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        assert (!(send_in[i] && cnt_q[i] == DEPTH_C));
        assert (!(credit_in[i] && !gnt_v[i] && cred_q[i] == DEPTH_C));
        if (valid[i] && !mid_q[i])
          assert (!(i == 1 && cur_route[i] == RT_CCW) && !(i == 2 && cur_route[i] == RT_CW));
      end
    end
  end

  assign data_out    = data_out_q;
  assign dest_out    = dest_out_q;
  assign is_tail_out = tail_out_q;
  assign send_out    = send_out_q;
  assign credit_out  = credit_out_q;

`ifdef RING_STOP_STATS_EN
  logic [31:0] stat_q [3];

  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < 3; o++) begin
      if (!rst_n) stat_q[o] <= '0;
      else        stat_q[o] <= stat_q[o] + 32'(send_out_q[o]);
    end
  end

  assign stat_flits_out = stat_q;
`endif

endmodule

// File: tb/tb_bidir_ring_stop.sv
`timescale 1ns/1ps
module tb_bidir_ring_stop;
  localparam int unsigned NN = 8, NID = 2, DW = 4, FW = 16, DEP = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] data_in [3];
  logic [DW-1:0] dest_in [3];
  logic [2:0]    is_tail_in, send_in, credit_out, is_tail_out, send_out, credit_in;
  logic [FW-1:0] data_out [3];
  logic [DW-1:0] dest_out [3];
`ifdef RING_STOP_STATS_EN
  logic [31:0]   stat_flits_out [3];
`endif

  bidir_ring_stop #(
    .NUM_NODES(NN), .NODE_ID(NID), .DEST_WIDTH(DW), .FLIT_WIDTH(FW),
    .FLIT_BUFFER_DEPTH(DEP), .DISABLE_SELFLOOP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in),
    .send_in(send_in), .credit_out(credit_out), .data_out(data_out), .dest_out(dest_out),
    .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in)
`ifdef RING_STOP_STATS_EN
    , .stat_flits_out(stat_flits_out)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit auto_cr  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            p;
    logic [FW-1:0] d;
    logic [DW-1:0] dst;
    logic          t;
    int            c;
  } obs_t;
  obs_t obsq[$];
  int   ccnt [3];

  // Monitor: every flit leaving the stop and every credit pulse, sampled mid-cycle.
  always @(negedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (send_out[p]) obsq.push_back('{p, data_out[p], dest_out[p], is_tail_out[p], cyc});
      if (credit_out[p]) ccnt[p]++;
    end
  end

  typedef struct {
    int            p;
    logic [DW-1:0] dst;
    int            ep;  // expected output port, 3 = discarded
  } vec_t;
  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_obs(input string nm, input int idx, input int p, input logic [FW-1:0] d, input int c);
    if (idx < obsq.size()) begin
      chk({nm, "_port"}, obsq[idx].p, p);
      chk({nm, "_data"}, obsq[idx].d, d);
      if (c >= 0) chk({nm, "_cycle"}, obsq[idx].c, c);
    end else begin
      n_assert++;
      n_fail++;
      $display("FAIL %s: flit %0d missing, got %0d flits", nm, idx, obsq.size());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_cr) credit_in[1] = send_out[1];
  endtask

  task automatic idle_send();
    send_in    = '0;
    is_tail_in = '0;
  endtask

  task automatic drive(input int p, input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic tl);
    send_in[p]    = 1'b1;
    data_in[p]    = d;
    dest_in[p]    = dst;
    is_tail_in[p] = tl;
  endtask

  task automatic clear_mon();
    obsq.delete();
    for (int p = 0; p < 3; p++) ccnt[p] = 0;
  endtask

  task automatic do_reset();
    idle_send();
    credit_in = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int cw, kc, cs, c3, c5;
    for (int p = 0; p < 3; p++) begin
      data_in[p] = '0;
      dest_in[p] = '0;
    end
    vt[0] = '{0, 4'd5, 1};  // dcw=3 -> CW
    vt[1] = '{0, 4'd7, 2};  // dcw=5 -> CCW
    vt[2] = '{0, 4'd6, 1};  // dcw=4 tie -> CW
    vt[3] = '{1, 4'd2, 0};  // CW input, dcw=0 -> local
    vt[4] = '{0, 4'd1, 2};  // dcw=7 -> CCW
    vt[5] = '{0, 4'd3, 1};  // dcw=1 -> CW
    vt[6] = '{2, 4'd0, 2};  // CCW input, dcw=6 -> CCW
    vt[7] = '{2, 4'd2, 0};  // CCW input -> local
    vt[8] = '{0, 4'd2, 3};  // local self-loop -> discarded
    vt[9] = '{1, 4'd4, 1};  // CW input, dcw=2 -> CW

    // Reset state
    do_reset();
    chk("rst_send_out", send_out, 3'b000);
    chk("rst_credit_out", credit_out, 3'b000);
    chk("rst_tail_out", is_tail_out, 3'b000);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("rst_data_out%0d", p), data_out[p], 0);
      chk($sformatf("rst_dest_out%0d", p), dest_out[p], 0);
    end

    // Three back-to-back single-flit packets with only two downstream credits
    clear_mon();
    drive(0, 16'hA001, 4'd3, 1'b1); tick();
    drive(0, 16'hA002, 4'd3, 1'b1); tick();
    drive(0, 16'hA003, 4'd3, 1'b1); tick();
    idle_send();
    ticks(6);
    chk("cred_stall_count", obsq.size(), 2);
    chk_obs("cred_first", 0, 1, 16'hA001, -1);
    chk_obs("cred_second", 1, 1, 16'hA002, -1);
    if (obsq.size() >= 2) chk("cred_back_to_back", obsq[1].c - obsq[0].c, 1);
    chk("cred_local_credit_out", ccnt[0], 2);
    clear_mon();
    credit_in[1] = 1'b1; tick(); kc = cyc;
    credit_in[1] = 1'b0;
    ticks(4);
    chk("cred_release_count", obsq.size(), 1);
    chk_obs("cred_release", 0, 1, 16'hA003, kc + 1);
    chk("cred_release_credit_out", ccnt[0], 1);

    // Routing table: one single-flit packet per vector
    do_reset();
    for (int i = 0; i < 10; i++) begin
      clear_mon();
      drive(vt[i].p, 16'hB000 + 16'(i), vt[i].dst, 1'b1); tick(); cw = cyc;
      idle_send();
      ticks(3);
      chk($sformatf("route%0d_credit_out", i), ccnt[vt[i].p], 1);
      if (vt[i].ep == 3) begin
        chk($sformatf("route%0d_no_send", i), obsq.size(), 0);
      end else begin
        chk($sformatf("route%0d_count", i), obsq.size(), 1);
        chk_obs($sformatf("route%0d", i), 0, vt[i].ep, 16'hB000 + 16'(i), cw + 1);
        if (obsq.size() >= 1) chk($sformatf("route%0d_dest", i), obsq[0].dst, vt[i].dst);
        credit_in[vt[i].ep] = 1'b1; tick();
        credit_in = '0;
      end
    end

    // Wormhole: 3-flit CW-input packet and 2-flit local packet contend for CW output.
    // A preceding local single-flit packet moves the CW output pointer to 1.
    do_reset();
    drive(0, 16'hC000, 4'd4, 1'b1); tick();
    idle_send();
    ticks(2);
    credit_in[1] = 1'b1; tick();
    credit_in[1] = 1'b0; tick();
    clear_mon();
    auto_cr = 1'b1;
    drive(1, 16'hC101, 4'd4, 1'b0); drive(0, 16'hC201, 4'd4, 1'b0); tick(); cs = cyc;
    drive(1, 16'hC102, 4'd4, 1'b0); drive(0, 16'hC202, 4'd4, 1'b1); tick();
    send_in[0] = 1'b0;
    drive(1, 16'hC103, 4'd4, 1'b1); tick();
    idle_send();
    ticks(8);
    auto_cr = 1'b0;
    credit_in = '0;
    chk("worm_count", obsq.size(), 5);
    chk_obs("worm_p1", 0, 1, 16'hC101, cs + 1);
    chk_obs("worm_p2", 1, 1, 16'hC102, cs + 2);
    chk_obs("worm_p3", 2, 1, 16'hC103, cs + 3);
    chk_obs("worm_l1", 3, 1, 16'hC201, cs + 4);
    chk_obs("worm_l2", 4, 1, 16'hC202, cs + 5);
    if (obsq.size() >= 5) begin
      chk("worm_tail_p3", obsq[2].t, 1'b1);
      chk("worm_tail_l2", obsq[4].t, 1'b1);
    end
    chk("worm_credit_out_local", ccnt[0], 2);
    chk("worm_credit_out_cw", ccnt[1], 3);

    // Credit counter at 1 with send and credit_in in the same cycle
    do_reset();
    clear_mon();
    drive(0, 16'hD001, 4'd3, 1'b1); tick();
    idle_send(); tick();
    drive(0, 16'hD002, 4'd3, 1'b1); tick(); c3 = cyc;
    drive(0, 16'hD003, 4'd3, 1'b1); credit_in[1] = 1'b1; tick();
    idle_send(); credit_in = '0;
    ticks(4);
    chk("cred_same_count", obsq.size(), 3);
    chk_obs("cred_same_d1", 0, 1, 16'hD001, -1);
    chk_obs("cred_same_d2", 1, 1, 16'hD002, c3 + 1);
    chk_obs("cred_same_d3", 2, 1, 16'hD003, c3 + 2);

    // Reset in the middle of a packet that holds the CW output lock
    do_reset();
    drive(0, 16'hE001, 4'd3, 1'b0); tick();
    drive(0, 16'hE002, 4'd3, 1'b0); tick();
    drive(0, 16'hE003, 4'd3, 1'b0); tick();
    idle_send();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    chk("midrst_send_out", send_out, 3'b000);
    chk("midrst_credit_out", credit_out, 3'b000);
    chk("midrst_data_out1", data_out[1], 0);
    clear_mon();
    drive(1, 16'hE101, 4'd4, 1'b1); tick(); c5 = cyc;
    drive(1, 16'hE102, 4'd4, 1'b1); tick();
    idle_send();
    ticks(5);
    chk("midrst_count", obsq.size(), 2);
    chk_obs("midrst_new1", 0, 1, 16'hE101, c5 + 1);
    chk_obs("midrst_new2", 1, 1, 16'hE102, c5 + 2);
    chk("midrst_local_credit_out", ccnt[0], 0);
`ifdef RING_STOP_STATS_EN
    chk("stats_cw_after_reset", stat_flits_out[1], 2);
`endif

    // Self-loop discard of a 2-flit local packet
    do_reset();
    clear_mon();
    drive(0, 16'hF001, 4'd2, 1'b0); tick();
    drive(0, 16'hF002, 4'd2, 1'b1); tick();
    idle_send();
    ticks(4);
    chk("selfloop_no_send", obsq.size(), 0);
    chk("selfloop_credit_out", ccnt[0], 2);
`ifdef RING_STOP_STATS_EN
    for (int p = 0; p < 3; p++) chk($sformatf("selfloop_stat%0d", p), stat_flits_out[p], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
